cnt_seq_ctrl: RTL and testbench
===============================

CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of count, limit and all count-related ports.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  begin a count sequence; sampled only in IDLE.
REQ-005 Port: stop  input  1  abort sequence; return to IDLE.
REQ-006 Port: pause  input  1  freeze count while high.
REQ-007 Port: limit  input  WIDTH  terminal/start value for the sequence.
REQ-008 Port: dir  input  1  0 = count up 0..limit; 1 = count down limit..0.
REQ-009 Port: mode  input  1  0 = one-shot; 1 = periodic (reload and continue).
REQ-010 Port: cnt  output  WIDTH  current count value, registered.
REQ-011 Port: busy  output  1  high in RUN or HOLD.
REQ-012 Port: tc  output  1  terminal-count strobe.
REQ-013 Port: done  output  1  one-shot completion strobe.

Function
REQ-014 FSM states: IDLE, RUN, HOLD, DONE.
REQ-015 IDLE, start=1, stop=0: latch limit/dir/mode; next edge -> RUN with cnt = 0 (dir=0) or limit (dir=1).
REQ-016 start is ignored in RUN, HOLD, DONE; limit/dir/mode changes after latch have no effect until next start.
REQ-017 Terminal value: latched limit for up; 0 for down; start value: 0 for up; latched limit for down.
REQ-018 RUN edge, pause=0, stop=0, cnt != terminal: cnt +1 (up) or -1 (down), modulo 2^WIDTH never reached by construction.
REQ-019 RUN edge, cnt == terminal: one-shot -> DONE, cnt holds terminal; periodic -> cnt = start value, stay RUN.
REQ-020 Sequence length: limit+1 RUN cycles per period; limit=0 gives tc every RUN cycle (periodic) or one RUN cycle (one-shot).
REQ-021 tc = (state==RUN) and cnt==terminal and pause==0 and stop==0; decoded from registers, no input path other than pause/stop gating.
REQ-022 RUN edge, pause=1, stop=0 -> HOLD, cnt unchanged; HOLD edge, pause=0 -> RUN, cnt unchanged; tc=0 in HOLD.
REQ-023 DONE lasts exactly one cycle, done=1, busy=0; next edge -> IDLE, cnt holds terminal.
REQ-024 stop=1 at any edge in RUN, HOLD or DONE -> IDLE, cnt = 0; stop has priority over pause, terminal and start.
REQ-025 IDLE: cnt holds last value, busy=0, tc=0, done=0.

Reset
REQ-026 rst=1 forces, without a clock edge: state IDLE, cnt 0, latched limit/dir/mode 0, busy 0, tc 0, done 0.
REQ-027 rst asserted mid-sequence discards the sequence; first start after release follows REQ-015.
REQ-028 Every register in the block uses the same asynchronous reset; no synchronous-reset-only flops.

Structure
REQ-029 Shared package cnt_seq_pkg: FSM state encoding (IDLE=0, RUN=1, HOLD=2, DONE=3, 2 bits), DIR_UP/DIR_DN, MODE_ONESHOT/MODE_PERIODIC constants.
REQ-030 One sub-module cnt_seq_core: WIDTH-bit loadable up/down counter (en, load, load_val, dir, q); FSM and strobe decode stay in cnt_seq_ctrl.

Verification (WIDTH=4)
REQ-031 Up one-shot, limit=9, start pulse -> cnt 0..9 over 10 cycles, tc with cnt=9, done next cycle, IDLE with cnt=9.
REQ-032 Down periodic, limit=3 -> cnt 3,2,1,0,3,2,...; tc with every cnt=0, period 4 cycles; busy stays 1.
REQ-033 Up periodic, limit=15 -> cnt 15 then 0 with tc at 15; pause high 3 cycles at cnt=4 -> cnt holds 4, busy=1, tc=0, resumes 5.
REQ-034 pause and stop high same cycle at cnt=6 -> IDLE, cnt=0, busy=0; start pulse while busy and limit change mid-RUN -> no effect.
REQ-035 rst pulsed asynchronously (between edges) at cnt=5 -> cnt=0, busy=0 immediately; limit=0 one-shot -> one RUN cycle with tc=1, then done=1.

Source files
------------

// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: shared state encoding and direction/mode constants for the count sequencer
package cnt_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// cnt_seq_ctrl_if: control/status bundle between a sequencer user and cnt_seq_ctrl
interface cnt_seq_ctrl_if #(parameter int WIDTH = 4);
  logic start, stop, pause, dir, mode, busy, tc, done;
  logic [WIDTH-1:0] limit, cnt;
  modport master(output start, stop, pause, limit, dir, mode, input cnt, busy, tc, done);
  modport slave(input start, stop, pause, limit, dir, mode, output cnt, busy, tc, done);
endinterface

// File: rtl/cnt_seq_core.sv
// cnt_seq_core: loadable up/down counter; load wins over count enable
module cnt_seq_core import cnt_seq_pkg::*; #(parameter int WIDTH = 4) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (load) q <= load_val;
    else if (en) q <= (dir == DIR_DN) ? q - WIDTH'(1) : q + WIDTH'(1);
endmodule

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: start/stop/pause sequencer driving an up/down counter over 0..limit,
// one-shot or periodic, with terminal-count and completion strobes
module cnt_seq_ctrl import cnt_seq_pkg::*; #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  cnt_seq_ctrl_if.slave bus
);
  state_t state, nxt;
  logic [WIDTH-1:0] lim_q, term, first, load_val;
  logic dir_q, mode_q, en, load, at_term, go;
  assign go = state == IDLE && bus.start && !bus.stop;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      lim_q <= '0;
      dir_q <= DIR_UP;
      mode_q <= MODE_ONESHOT;
    end else begin
      state <= nxt;
      if (go) begin
        lim_q <= bus.limit;
        dir_q <= bus.dir;
        mode_q <= bus.mode;
      end
    end
  assign term = (dir_q == DIR_DN) ? '0 : lim_q;
  assign first = (dir_q == DIR_DN) ? lim_q : '0;
  assign at_term = bus.cnt == term;
  always_comb begin
    nxt = state;
    en = 1'b0;
    load = 1'b0;
    load_val = '0;
    if (state != IDLE && bus.stop) begin
      nxt = IDLE;
      load = 1'b1;
    end else
      case (state)
        IDLE: if (go) begin
          nxt = RUN;
          load = 1'b1;
          load_val = (bus.dir == DIR_DN) ? bus.limit : '0;
        end
        RUN: if (bus.pause) nxt = HOLD;
          else if (!at_term) en = 1'b1;
          else if (mode_q == MODE_PERIODIC) begin
            load = 1'b1;
            load_val = first;
          end else nxt = DONE;
        HOLD: nxt = bus.pause ? HOLD : RUN;
        DONE: nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  cnt_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .dir(dir_q), .q(bus.cnt)
  );
  assign bus.busy = state == RUN || state == HOLD;
  assign bus.tc = state == RUN && at_term && !bus.pause && !bus.stop;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: directed stimulus, sequence-level reference model checked every cycle,
// plus hand-computed spot checks
module tb_cnt_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  int n_cmp = 0, n_bad = 0;
  cnt_seq_ctrl_if #(.WIDTH(4)) bus();
  cnt_seq_ctrl #(.WIDTH(4)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // reference: a sequence is "running", "frozen" (paused) or "finishing" (completion cycle)
  int m_cnt = 0, m_lim = 0;
  bit m_dn = 0, m_per = 0, running = 0, frozen = 0, finishing = 0;
  function automatic int m_term(); return m_dn ? 0 : m_lim; endfunction
  function automatic int m_first(); return m_dn ? m_lim : 0; endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      {running, frozen, finishing, m_dn, m_per} = '0;
      m_cnt = 0;
      m_lim = 0;
    end else if (!running && !frozen && !finishing) begin
      if (bus.start && !bus.stop) begin
        m_lim = int'(bus.limit);
        m_dn = bus.dir;
        m_per = bus.mode;
        m_cnt = m_first();
        running = 1;
      end
    end else if (bus.stop) begin
      {running, frozen, finishing} = '0;
      m_cnt = 0;
    end else if (finishing) finishing = 0;
    else if (frozen) begin
      if (!bus.pause) {frozen, running} = 2'b01;
    end else if (bus.pause) {frozen, running} = 2'b10;
    else if (m_cnt != m_term()) m_cnt += m_dn ? -1 : 1;
    else if (m_per) m_cnt = m_first();
    else {running, finishing} = 2'b01;
    #1;
    chk("model_cnt", int'(bus.cnt), m_cnt);
    chk("model_busy", int'(bus.busy), int'(running || frozen));
    chk("model_done", int'(bus.done), int'(finishing));
    chk("model_tc", int'(bus.tc), int'(running && m_cnt == m_term() && !bus.pause && !bus.stop));
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input int lim, input bit dn, input bit per);
    bus.limit = 4'(lim);
    bus.dir = dn;
    bus.mode = per;
    bus.start = 1;
    cyc();
    bus.start = 0;
  endtask

  initial begin
    {bus.start, bus.stop, bus.pause, bus.dir, bus.mode} = '0;
    bus.limit = '0;
    #1;
    chk("rst_cnt", int'(bus.cnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tc", int'(bus.tc), 0);
    chk("rst_done", int'(bus.done), 0);
    cyc();
    rst = 0;
    cyc(2);
    // up one-shot 0..9
    launch(9, 0, 0);
    chk("up_first", int'(bus.cnt), 0);
    chk("up_busy", int'(bus.busy), 1);
    cyc(9);
    chk("up_last", int'(bus.cnt), 9);
    chk("up_tc", int'(bus.tc), 1);
    cyc();
    chk("up_done", int'(bus.done), 1);
    chk("up_done_busy", int'(bus.busy), 0);
    cyc();
    chk("up_idle_cnt", int'(bus.cnt), 9);
    chk("up_idle_done", int'(bus.done), 0);
    // down periodic 3,2,1,0,...
    launch(3, 1, 1);
    chk("dn_first", int'(bus.cnt), 3);
    cyc(3);
    chk("dn_zero", int'(bus.cnt), 0);
    chk("dn_tc", int'(bus.tc), 1);
    cyc();
    chk("dn_reload", int'(bus.cnt), 3);
    chk("dn_tc_off", int'(bus.tc), 0);
    cyc(3);
    chk("dn_tc2", int'(bus.tc), 1);
    chk("dn_busy", int'(bus.busy), 1);
    bus.stop = 1;
    cyc();
    bus.stop = 0;
    chk("dn_stop_cnt", int'(bus.cnt), 0);
    // up periodic to 15 with a 3-cycle pause at 4
    launch(15, 0, 1);
    cyc(4);
    chk("p_at4", int'(bus.cnt), 4);
    bus.pause = 1;
    chk("p_tc_gate", int'(bus.tc), 0);
    cyc(3);
    chk("p_hold_cnt", int'(bus.cnt), 4);
    chk("p_hold_busy", int'(bus.busy), 1);
    chk("p_hold_tc", int'(bus.tc), 0);
    bus.pause = 0;
    cyc();
    chk("p_resume", int'(bus.cnt), 4);
    cyc();
    chk("p_next", int'(bus.cnt), 5);
    cyc(10);
    chk("p_15", int'(bus.cnt), 15);
    chk("p_tc15", int'(bus.tc), 1);
    cyc();
    chk("p_wrap", int'(bus.cnt), 0);
    bus.stop = 1;
    cyc();
    bus.stop = 0;
    // ignored start/limit mid-run, then pause+stop together
    launch(9, 0, 0);
    cyc();
    bus.start = 1;
    bus.limit = 4'd2;
    cyc(2);
    bus.start = 0;
    chk("ign_cnt", int'(bus.cnt), 3);
    cyc(3);
    chk("ps_at6", int'(bus.cnt), 6);
    bus.pause = 1;
    bus.stop = 1;
    cyc();
    {bus.pause, bus.stop} = '0;
    chk("ps_cnt", int'(bus.cnt), 0);
    chk("ps_busy", int'(bus.busy), 0);
    // asynchronous reset mid-sequence
    launch(9, 0, 0);
    cyc(5);
    chk("ar_at5", int'(bus.cnt), 5);
    #2 rst = 1;
    #1;
    chk("ar_cnt", int'(bus.cnt), 0);
    chk("ar_busy", int'(bus.busy), 0);
    cyc();
    rst = 0;
    cyc();
    // limit=0 one-shot
    launch(0, 0, 0);
    chk("z_tc", int'(bus.tc), 1);
    chk("z_busy", int'(bus.busy), 1);
    cyc();
    chk("z_done", int'(bus.done), 1);
    cyc();
    chk("z_idle", int'(bus.done), 0);
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
